// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package regfile_arb_pkg;

  localparam int unsigned ZERO_REG_DEFAULT   = 31;
  localparam int unsigned ADDR_WIDTH_DEFAULT = 5;
  localparam int unsigned DATA_WIDTH_DEFAULT = 64;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  typedef struct packed {
    logic [ADDR_WIDTH_DEFAULT-1:0] addr;
    logic [DATA_WIDTH_DEFAULT-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Two writeback requester channels (A = ALU result, B = load data) into the arbiter.
interface regfile_write_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT
);
  logic                  a_valid;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_ready;
  logic                  b_valid;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  b_ready;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/regfile_write_arbiter_rr.sv
// Two-way round-robin grant logic with the last-grant state flop.
module rr_arbiter2
  import regfile_arb_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   hold,
  input  logic   aValid,
  input  logic   bValid,
  output logic   aGrant,
  output logic   bGrant,
  output grant_t lastGrant
);
  grant_t lastGrantNext;

  // Reset to B so that A wins the first contention.
  always_ff @(posedge clk) begin
    if (!reset_n) lastGrant <= GRANT_B;
    else          lastGrant <= lastGrantNext;
  end

  always_comb begin
    aGrant        = 1'b0;
    bGrant        = 1'b0;
    lastGrantNext = lastGrant;
    if (reset_n && !hold) begin
      aGrant = aValid && (!bValid || (lastGrant == GRANT_B));
      bGrant = bValid && (!aValid || (lastGrant == GRANT_A));
      if (aGrant)      lastGrantNext = GRANT_A;
      else if (bGrant) lastGrantNext = GRANT_B;
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between ALU and load writeback,
// registering the granted write and suppressing writes to the zero register.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int unsigned ZERO_REG   = ZERO_REG_DEFAULT
)(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    hold,
  regfile_write_arbiter_if.slave  req,
  output logic                    RegWrite,
  output logic [ADDR_WIDTH-1:0]   WriteRegister,
  output logic [DATA_WIDTH-1:0]   WriteData,
  output logic                    last_grant
);
  localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(ZERO_REG);

  logic                  aGrant;
  logic                  bGrant;
  grant_t                lastGrant;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selData;

  rr_arbiter2 uArb (
    .clk       (clk),
    .reset_n   (reset_n),
    .hold      (hold),
    .aValid    (req.a_valid),
    .bValid    (req.b_valid),
    .aGrant    (aGrant),
    .bGrant    (bGrant),
    .lastGrant (lastGrant)
  );

  assign req.a_ready = aGrant;
  assign req.b_ready = bGrant;
  assign last_grant  = lastGrant;

  always_comb begin
    selAddr = req.a_addr;
    selData = req.a_data;
    if (bGrant) begin
      selAddr = req.b_addr;
      selData = req.b_data;
    end
  end

  // Zero-register writes still complete the handshake; only the enable is dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (aGrant || bGrant) begin
      RegWrite      <= (selAddr != ZeroAddr);
      WriteRegister <= selAddr;
      WriteData     <= selData;
    end else begin
      RegWrite      <= 1'b0;
    end
  end
endmodule
